// File: rtl/dmem_resp.sv
// Data-memory responder: one load/store in flight, fixed LATENCY, held response.
// Define DMEM_RESP_ERR_EN for error detection; otherwise accesses are forced aligned and wrap.
module dmem_resp #(
   parameter int          DEPTH_WORDS = 16384,
   parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
   parameter int          LATENCY     = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic        req_rw,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_unsign,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);
   // state | meaning
   // IDLE  | waiting for a request, req_ready=1
   // BUSY  | counting down the latency; access performed when the counter reaches 0
   // RESP  | response held until resp_ready

   localparam int              AW       = $clog2(DEPTH_WORDS);
   localparam int              CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam logic [CW-1:0]   CNT_LOAD = CW'(LATENCY - 1);
   localparam logic [32:0]     SPAN     = 33'(DEPTH_WORDS) << 2;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [31:0]   a_addr;
   logic [31:0]   a_wdata;
   logic          a_rw;
   logic          a_uns;
   logic [1:0]    a_size;

   logic [31:0]   mem [DEPTH_WORDS];

   logic [31:0]   offset;
   logic [1:0]    size_eff;
   logic [1:0]    lane;
   logic          err_c;
   logic [AW-1:0] widx;
   logic [31:0]   word;
   logic [31:0]   shifted;
   logic [31:0]   rd_c;
   logic [31:0]   wd;
   logic [3:0]    be;
   logic          commit;

   always_comb begin
      offset = a_addr - BASE_ADDR;
`ifdef DMEM_RESP_ERR_EN
      size_eff = a_size;
      lane     = a_addr[1:0];
      err_c    = (a_size == 2'b11)
               || (a_size == 2'b01 && a_addr[0])
               || (a_size == 2'b10 && a_addr[1:0] != 2'b00)
               || ({1'b0, offset} >= SPAN);
`else
      size_eff = (a_size == 2'b11) ? 2'b10 : a_size;
      case (size_eff)
         2'b00:   lane = a_addr[1:0];
         2'b01:   lane = {a_addr[1], 1'b0};
         default: lane = 2'b00;
      endcase
      err_c = 1'b0;
`endif
      // dropping the upper offset bits gives the wrap in the permissive build
      widx    = offset[AW+1:2];
      word    = mem[widx];
      shifted = word >> {lane, 3'b000};
      case (size_eff)
         2'b00:   rd_c = a_uns ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
         2'b01:   rd_c = a_uns ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
         default: rd_c = word;
      endcase
      case (size_eff)
         2'b00: begin
            be = 4'b0001 << lane;
            wd = {4{a_wdata[7:0]}};
         end
         2'b01: begin
            be = lane[1] ? 4'b1100 : 4'b0011;
            wd = {2{a_wdata[15:0]}};
         end
         default: begin
            be = 4'b1111;
            wd = a_wdata;
         end
      endcase
      commit = (state == BUSY) && (cnt == '0) && !reset;
   end

   logic unused_bits;
   assign unused_bits = ^{offset, shifted};

   // storage has no reset; a store lands only on the BUSY->RESP edge
   always_ff @(posedge clock) begin
      if (commit && a_rw && !err_c) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem[widx][8*i +: 8] <= wd[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state      <= IDLE;
         cnt        <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  a_addr    <= req_addr;
                  a_rw      <= req_rw;
                  a_wdata   <= req_wdata;
                  a_size    <= req_size;
                  a_uns     <= req_unsign;
                  cnt       <= CNT_LOAD;
                  req_ready <= 1'b0;
                  state     <= BUSY;
               end
            end
            BUSY: begin
               if (cnt == '0) begin
                  resp_valid <= 1'b1;
                  resp_err   <= err_c;
                  resp_rdata <= (a_rw || err_c) ? 32'h0 : rd_c;
                  state      <= RESP;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_resp.sv
// Bench for dmem_resp: directed vector table, reset abort, LATENCY=1 range check,
// then random traffic against a byte-array memory model.
module tb_dmem_resp;
   localparam logic [31:0] BASE   = 32'h0100_0000;
   localparam int          DEPTH0 = 16384;
   localparam int          LAT0   = 2;
   localparam int          DEPTH1 = 64;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req_valid = 1'b0, req_ready;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_rw = 1'b0, req_unsign = 1'b0;
   logic [1:0]  req_size = 2'b10;
   logic        resp_valid, resp_ready = 1'b0, resp_err;
   logic [31:0] resp_rdata;
   logic        v1 = 1'b0, rdy1, rv1, rr1 = 1'b0, er1;
   logic [31:0] rd1;

   int tests = 0;
   int fails = 0;
   logic [7:0] mm [64];

   always #5 clock = ~clock;

   dmem_resp #(.DEPTH_WORDS(DEPTH0), .BASE_ADDR(BASE), .LATENCY(LAT0)) u0 (
      .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsign(req_unsign), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err));

   dmem_resp #(.DEPTH_WORDS(DEPTH1), .BASE_ADDR(BASE), .LATENCY(1)) u1 (
      .clock(clock), .reset(reset), .req_valid(v1), .req_ready(rdy1),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata), .req_size(req_size),
      .req_unsign(req_unsign), .resp_valid(rv1), .resp_ready(rr1),
      .resp_rdata(rd1), .resp_err(er1));

   typedef struct {
      logic [31:0] addr;
      logic        rw;
      logic [31:0] wdata;
      logic [1:0]  size;
      logic        uns;
      int          hold;
      logic [31:0] rd;
      logic        err;
   } vec_t;

   vec_t vt [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Reference: byte-addressed window of 64 bytes at BASE, little-endian.
   task automatic model(input logic [31:0] addr, input logic rw, input logic [31:0] wdata,
                        input logic [1:0] size, input logic uns,
                        output logic [31:0] rd, output logic err);
      longint unsigned off, span, ea;
      int n;
      logic [31:0] v;
      off  = 64'(addr - BASE);
      span = 64'(DEPTH0) * 4;
      n    = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
      rd   = '0;
      err  = 1'b0;
`ifdef DMEM_RESP_ERR_EN
      if (size == 2'd3 || (off % 64'(n)) != 0 || off >= span) begin
         err = 1'b1;
         return;
      end
      ea = off;
`else
      ea = off % span;
      ea = ea - (ea % 64'(n));
`endif
      if (rw) begin
         for (int i = 0; i < n; i++) mm[int'(ea) + i] = wdata[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v = v | (32'(mm[int'(ea) + i]) << (8*i));
         if (!uns && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
         rd = v;
      end
   endtask

   task automatic do_req(input string name, input logic [31:0] addr, input logic rw,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input int hold, input logic [31:0] exp_rd, input logic exp_err);
      int c;
      @(negedge clock);
      c = 0;
      while (!req_ready && c < 20) begin
         @(negedge clock);
         c++;
      end
      check({name, " ready"}, 32'(req_ready), 32'd1);
      req_addr = addr; req_rw = rw; req_wdata = wdata; req_size = size; req_unsign = uns;
      req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      req_addr = $urandom; req_wdata = $urandom; req_rw = 1'($urandom); req_size = 2'($urandom);
      c = 0;
      while (!resp_valid && c < 20) begin
         @(negedge clock);
         c++;
      end
      check({name, " latency"}, 32'(c), 32'(LAT0));
      check({name, " rdata"}, resp_rdata, exp_rd);
      check({name, " err"}, 32'(resp_err), 32'(exp_err));
      for (int h = 0; h < hold; h++) begin
         req_valid = 1'b1;
         @(negedge clock);
         check({name, " hold rdata"}, resp_rdata, exp_rd);
         check({name, " hold flags"}, 32'({resp_valid, req_ready, resp_err}), 32'({1'b1, 1'b0, exp_err}));
      end
      resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready = 1'b0;
      req_valid  = 1'b0;
      check({name, " release"}, 32'({resp_valid, req_ready}), 32'b01);
   endtask

   task automatic t1_req(input string name, input logic [31:0] addr, input logic rw,
                         input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
      int c;
      @(negedge clock);
      req_addr = addr; req_rw = rw; req_wdata = wdata; req_size = 2'b10; req_unsign = 1'b0;
      v1 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      v1 = 1'b0;
      c = 0;
      while (!rv1 && c < 20) begin
         @(negedge clock);
         c++;
      end
      check({name, " latency"}, 32'(c), 32'd1);
      check({name, " rdata"}, rd1, exp_rd);
      check({name, " err"}, 32'(er1), 32'(exp_err));
      rr1 = 1'b1;
      @(posedge clock);
      @(negedge clock);
      rr1 = 1'b0;
      check({name, " release"}, 32'({rv1, rdy1}), 32'b01);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected summary");
      $fatal(1);
   end

   initial begin
      logic [31:0] erd, a;
      logic        eerr, rw, uns;
      logic [1:0]  sz;
      int          bad;

      vt.push_back('{BASE + 32'h10, 1'b1, 32'hDEADBEEF, 2'd2, 1'b0, 0, 32'h0, 1'b0});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0,       2'd2, 1'b0, 0, 32'hDEADBEEF, 1'b0});
      vt.push_back('{BASE + 32'h13, 1'b1, 32'h00000080, 2'd0, 1'b0, 0, 32'h0, 1'b0});
      vt.push_back('{BASE + 32'h13, 1'b0, 32'h0, 2'd0, 1'b0, 0, 32'hFFFFFF80, 1'b0});
      vt.push_back('{BASE + 32'h13, 1'b0, 32'h0, 2'd0, 1'b1, 0, 32'h00000080, 1'b0});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 5, 32'h80ADBEEF, 1'b0});
`ifdef DMEM_RESP_ERR_EN
      vt.push_back('{BASE + 32'h12, 1'b0, 32'h0,       2'd2, 1'b0, 0, 32'h0, 1'b1});
      vt.push_back('{BASE + 32'h12, 1'b1, 32'h11112222, 2'd2, 1'b0, 0, 32'h0, 1'b1});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 0, 32'h80ADBEEF, 1'b0});
      vt.push_back('{BASE + 32'h12, 1'b0, 32'h0, 2'd1, 1'b0, 0, 32'hFFFF80AD, 1'b0});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0, 2'd3, 1'b0, 0, 32'h0, 1'b1});
      vt.push_back('{BASE + 32'h11, 1'b0, 32'h0, 2'd1, 1'b0, 0, 32'h0, 1'b1});
`else
      vt.push_back('{BASE + 32'h12, 1'b0, 32'h0,       2'd2, 1'b0, 0, 32'h80ADBEEF, 1'b0});
      vt.push_back('{BASE + 32'h12, 1'b1, 32'h11112222, 2'd2, 1'b0, 0, 32'h0, 1'b0});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0, 2'd2, 1'b0, 0, 32'h11112222, 1'b0});
      vt.push_back('{BASE + 32'h12, 1'b0, 32'h0, 2'd1, 1'b0, 0, 32'h00001111, 1'b0});
      vt.push_back('{BASE + 32'h10, 1'b0, 32'h0, 2'd3, 1'b0, 0, 32'h11112222, 1'b0});
      vt.push_back('{BASE + 32'h11, 1'b0, 32'h0, 2'd1, 1'b0, 0, 32'h00002222, 1'b0});
`endif
      vt.push_back('{BASE + 32'h14, 1'b1, 32'h0000BEEF, 2'd1, 1'b0, 0, 32'h0, 1'b0});
      vt.push_back('{BASE + 32'h14, 1'b0, 32'h0, 2'd1, 1'b1, 0, 32'h0000BEEF, 1'b0});
      vt.push_back('{BASE + 32'h15, 1'b0, 32'h0, 2'd0, 1'b0, 0, 32'hFFFFFFBE, 1'b0});
      vt.push_back('{BASE + 32'h14, 1'b0, 32'h0, 2'd0, 1'b1, 2, 32'h000000EF, 1'b0});
      vt.push_back('{BASE + 32'h20, 1'b1, 32'hA5A55A5A, 2'd2, 1'b0, 0, 32'h0, 1'b0});
      vt.push_back('{BASE + 32'h20, 1'b0, 32'h0, 2'd2, 1'b0, 0, 32'hA5A55A5A, 1'b0});

      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("reset flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
      check("reset rdata", resp_rdata, 32'h0);
      check("reset flags u1", 32'({rdy1, rv1, er1}), 32'b100);

      foreach (vt[i])
         do_req($sformatf("vec%0d", i), vt[i].addr, vt[i].rw, vt[i].wdata, vt[i].size,
                vt[i].uns, vt[i].hold, vt[i].rd, vt[i].err);

      // store aborted by reset one cycle after acceptance
      @(negedge clock);
      req_addr = BASE + 32'h20; req_rw = 1'b1; req_wdata = 32'h12345678; req_size = 2'b10;
      req_valid = 1'b1;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("abort flags", 32'({req_ready, resp_valid, resp_err}), 32'b100);
      check("abort rdata", resp_rdata, 32'h0);
      bad = 0;
      repeat (LAT0 + 2) begin
         @(negedge clock);
         if (resp_valid) bad++;
      end
      check("abort no response", 32'(bad), 32'd0);
      do_req("abort reload", BASE + 32'h20, 1'b0, 32'h0, 2'd2, 1'b0, 0, 32'hA5A55A5A, 1'b0);

      // LATENCY=1 instance with a 64-word store
      t1_req("u1 store", BASE, 1'b1, 32'hCAFEF00D, 32'h0, 1'b0);
      t1_req("u1 load", BASE, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
`ifdef DMEM_RESP_ERR_EN
      t1_req("u1 range", BASE + 32'd256, 1'b0, 32'h0, 32'h0, 1'b1);
`else
      t1_req("u1 range", BASE + 32'd256, 1'b0, 32'h0, 32'hCAFEF00D, 1'b0);
`endif

      for (int w = 0; w < 16; w++) begin
         a = BASE + 32'(4 * w);
         rw = 1'b1;
         model(a, rw, 32'($urandom), 2'd2, 1'b0, erd, eerr);
         do_req("prefill", a, 1'b1, {mm[4*w+3], mm[4*w+2], mm[4*w+1], mm[4*w]},
                2'd2, 1'b0, 0, erd, eerr);
      end

      for (int t = 0; t < 250; t++) begin
         logic [31:0] wd;
         a   = BASE + 32'($urandom_range(0, 63));
         if ($urandom_range(0, 7) == 0) a = a + 32'(DEPTH0 * 4);
         rw  = 1'($urandom);
         uns = 1'($urandom);
         sz  = 2'($urandom);
         wd  = $urandom;
         model(a, rw, wd, sz, uns, erd, eerr);
         do_req($sformatf("rand%0d", t), a, rw, wd, sz, uns, $urandom_range(0, 3), erd, eerr);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
